// File: rtl/sr_pkg.sv
// Shared state encodings and parameter defaults for the SR flop command sequencer.
// Latency: none, declarations only. Backpressure: none.
// The optional SR_MIRROR_EN build reuses these encodings unchanged.
package sr_pkg;

    localparam logic [1:0] SR_IDLE    = 2'd0;
    localparam logic [1:0] SR_DRIVE_S = 2'd1;
    localparam logic [1:0] SR_DRIVE_R = 2'd2;
    localparam logic [1:0] SR_GAP     = 2'd3;

    localparam int SR_PULSE_CYCLES_DEF = 1;
    localparam int SR_GAP_CYCLES_DEF   = 2;
    localparam int SR_CNT_W_DEF        = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = SR_IDLE,
        ST_DRIVE_S = SR_DRIVE_S,
        ST_DRIVE_R = SR_DRIVE_R,
        ST_GAP     = SR_GAP
    } sr_state_e;

endpackage

// File: rtl/sr_cmd_sequencer_if.sv
// Request/drive bundle between a requester and the SR flop command sequencer.
// Latency: none, wiring only. Backpressure: requests are level-sampled and latched, never refused.
// q_mirror exists only when SR_MIRROR_EN is defined.
interface sr_cmd_sequencer_if;

    logic set_req;
    logic clr_req;
    logic s;
    logic r;
    logic set_ack;
    logic clr_ack;
    logic busy;
`ifdef SR_MIRROR_EN
    logic q_mirror;

    modport master (
        output set_req, clr_req,
        input  s, r, set_ack, clr_ack, busy, q_mirror
    );

    modport slave (
        input  set_req, clr_req,
        output s, r, set_ack, clr_ack, busy, q_mirror
    );
`else
    modport master (
        output set_req, clr_req,
        input  s, r, set_ack, clr_ack, busy
    );

    modport slave (
        input  set_req, clr_req,
        output s, r, set_ack, clr_ack, busy
    );
`endif

endinterface

// File: rtl/sr_cycle_counter.sv
// Loadable down-counter timing the pulse and gap phases; saturates at zero.
// Latency: load takes effect on the next edge; zero is a decode of the register.
// Backpressure: none, counts every cycle it is not loaded.
module sr_cycle_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Arbitrates set/clear requests into exclusive fixed-width s/r pulses with a forced idle gap.
// Latency: request at edge T drives s/r and ack in cycle T+1 when idle.
// Backpressure: requests during a command are latched as pending flags; define SR_MIRROR_EN to filter redundant ones.
module sr_cmd_sequencer
    import sr_pkg::*;
#(
    parameter int PULSE_CYCLES = SR_PULSE_CYCLES_DEF,
    parameter int GAP_CYCLES   = SR_GAP_CYCLES_DEF,
    parameter int CNT_W        = SR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sr_cmd_sequencer_if.slave    bus_if
);

    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(GAP_CYCLES - 1);

    sr_state_e        r_state;
    sr_state_e        w_state_nxt;
    logic             r_s_drv;
    logic             r_r_drv;
    logic             r_set_ack;
    logic             r_clr_ack;
    logic             r_set_pend;
    logic             r_clr_pend;
    logic             r_last_set;
    logic             w_set_cand;
    logic             w_clr_cand;
    logic             w_srv_set;
    logic             w_srv_clr;
    logic             w_red_set;
    logic             w_red_clr;
    logic             w_ack_set;
    logic             w_ack_clr;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_cnt_zero;
`ifdef SR_MIRROR_EN
    logic             r_q_mirror;
`endif

    assign w_set_cand = r_set_pend | bus_if.set_req;
    assign w_clr_cand = r_clr_pend | bus_if.clr_req;
    assign w_ack_set  = w_srv_set | w_red_set;
    assign w_ack_clr  = w_srv_clr | w_red_clr;

    sr_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_srv_set   = 1'b0;
        w_srv_clr   = 1'b0;
        w_red_set   = 1'b0;
        w_red_clr   = 1'b0;
        w_load      = 1'b0;
        w_load_val  = LD_PULSE;
        unique case (r_state)
            ST_IDLE: begin
`ifdef SR_MIRROR_EN
                // A request matching the known flop state is acked without a pulse, ahead of the other kind.
                if (w_set_cand && r_q_mirror) begin
                    w_red_set = 1'b1;
                end else if (w_clr_cand && !r_q_mirror) begin
                    w_red_clr = 1'b1;
                end else
`endif
                if (w_set_cand && (!w_clr_cand || !r_last_set)) begin
                    w_srv_set = 1'b1;
                end else if (w_clr_cand) begin
                    w_srv_clr = 1'b1;
                end
                if (w_srv_set) begin
                    w_state_nxt = ST_DRIVE_S;
                    w_load      = 1'b1;
                end else if (w_srv_clr) begin
                    w_state_nxt = ST_DRIVE_R;
                    w_load      = 1'b1;
                end
            end
            ST_DRIVE_S, ST_DRIVE_R: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_GAP;
                    w_load      = 1'b1;
                    w_load_val  = LD_GAP;
                end
            end
            ST_GAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_s_drv    <= 1'b0;
            r_r_drv    <= 1'b0;
            r_set_ack  <= 1'b0;
            r_clr_ack  <= 1'b0;
            r_set_pend <= 1'b0;
            r_clr_pend <= 1'b0;
            r_last_set <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_s_drv    <= (w_state_nxt == ST_DRIVE_S);
            r_r_drv    <= (w_state_nxt == ST_DRIVE_R);
            r_set_ack  <= w_ack_set;
            r_clr_ack  <= w_ack_clr;
            // Service on this edge wins over a request seen on the same edge, so bursts merge.
            r_set_pend <= ~w_ack_set & (r_set_pend | bus_if.set_req);
            r_clr_pend <= ~w_ack_clr & (r_clr_pend | bus_if.clr_req);
            if (w_srv_set) begin
                r_last_set <= 1'b1;
            end else if (w_srv_clr) begin
                r_last_set <= 1'b0;
            end
        end
    end

`ifdef SR_MIRROR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_mirror <= 1'b0;
        end else if (r_state == ST_DRIVE_S && w_state_nxt == ST_GAP) begin
            r_q_mirror <= 1'b1;
        end else if (r_state == ST_DRIVE_R && w_state_nxt == ST_GAP) begin
            r_q_mirror <= 1'b0;
        end
    end

    assign bus_if.q_mirror = r_q_mirror;
`endif

    assign bus_if.s       = r_s_drv;
    assign bus_if.r       = r_r_drv;
    assign bus_if.set_ack = r_set_ack;
    assign bus_if.clr_ack = r_clr_ack;
    assign bus_if.busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed bench for sr_cmd_sequencer: three instances (pulse widths 1, 3, 4) with hand-computed vectors.
// Observed vector order is {s, r, set_ack, clr_ack, busy}; SR_MIRROR_EN switches in the mirror sequence.
module tb_sr_cmd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a = 1'b1;
    logic rst_n_b = 1'b1;
    logic rst_n_c = 1'b1;

    int errors = 0;
    int checks = 0;

    sr_cmd_sequencer_if if_a();
    sr_cmd_sequencer_if if_b();
    sr_cmd_sequencer_if if_c();

    sr_cmd_sequencer #(.PULSE_CYCLES(1), .GAP_CYCLES(2), .CNT_W(4))
        dut_a (.clk(clk), .rst_n(rst_n_a), .bus_if(if_a.slave));
    sr_cmd_sequencer #(.PULSE_CYCLES(3), .GAP_CYCLES(2), .CNT_W(4))
        dut_b (.clk(clk), .rst_n(rst_n_b), .bus_if(if_b.slave));
    sr_cmd_sequencer #(.PULSE_CYCLES(4), .GAP_CYCLES(2), .CNT_W(4))
        dut_c (.clk(clk), .rst_n(rst_n_c), .bus_if(if_c.slave));

    wire [4:0] obs_a = {if_a.s, if_a.r, if_a.set_ack, if_a.clr_ack, if_a.busy};
    wire [4:0] obs_b = {if_b.s, if_b.r, if_b.set_ack, if_b.clr_ack, if_b.busy};
    wire [4:0] obs_c = {if_c.s, if_c.r, if_c.set_ack, if_c.clr_ack, if_c.busy};

    // Burst-merge expectations for PULSE_CYCLES=3, sample k taken after edge T+k.
    logic [0:12] ev_s  = 13'b1110000000000;
    logic [0:12] ev_r  = 13'b0000001110000;
    logic [0:12] ev_sa = 13'b1000000000000;
    logic [0:12] ev_ca = 13'b0000001000000;
    logic [0:12] ev_b  = 13'b1111101111100;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    initial begin
        if_a.set_req = 1'b0; if_a.clr_req = 1'b0;
        if_b.set_req = 1'b0; if_b.clr_req = 1'b0;
        if_c.set_req = 1'b0; if_c.clr_req = 1'b0;
        #1;
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        #1;
        chk("reset_a", obs_a, 5'b00000);
        chk("reset_b", obs_b, 5'b00000);
        chk("reset_c", obs_c, 5'b00000);
`ifdef SR_MIRROR_EN
        chk("reset_qm", {4'b0, if_a.q_mirror}, 5'b00000);
`endif
        cyc(); cyc();
        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
        cyc();

        // Basic set on A
        if_a.set_req = 1'b1; cyc(); if_a.set_req = 1'b0;
        chk("basic_pulse", obs_a, 5'b10101);
        cyc(); chk("basic_gap1", obs_a, 5'b00001);
        cyc(); chk("basic_gap2", obs_a, 5'b00001);
        cyc(); chk("basic_idle", obs_a, 5'b00000);

`ifndef SR_MIRROR_EN
        // Tie after a set was served: clear goes first
        if_a.set_req = 1'b1; if_a.clr_req = 1'b1; cyc();
        if_a.set_req = 1'b0; if_a.clr_req = 1'b0;
        chk("tie_alt_r", obs_a, 5'b01011);
        cyc(); chk("tie_alt_gap", obs_a, 5'b00001);
        cyc(); cyc(); chk("tie_alt_idle", obs_a, 5'b00000);
        cyc(); chk("tie_alt_s", obs_a, 5'b10101);
        cyc(); cyc(); cyc(); chk("tie_alt_done", obs_a, 5'b00000);

        // Fresh reset: set wins the first tie, clear follows 4 cycles later
        rst_n_a = 1'b0; #1;
        chk("reset_a2", obs_a, 5'b00000);
        cyc(); rst_n_a = 1'b1; cyc();
        if_a.set_req = 1'b1; if_a.clr_req = 1'b1; cyc();
        if_a.set_req = 1'b0; if_a.clr_req = 1'b0;
        chk("tie_s", obs_a, 5'b10101);
        cyc(); chk("tie_gap1", obs_a, 5'b00001);
        cyc(); chk("tie_gap2", obs_a, 5'b00001);
        cyc(); chk("tie_idle", obs_a, 5'b00000);
        cyc(); chk("tie_r", obs_a, 5'b01011);
        cyc(); cyc(); cyc(); chk("tie_done", obs_a, 5'b00000);

        // Set held into its own drive cycle is served again after the gap
        if_a.set_req = 1'b1; cyc();
        chk("same_first", obs_a, 5'b10101);
        cyc(); if_a.set_req = 1'b0;
        chk("same_gap1", obs_a, 5'b00001);
        cyc(); chk("same_gap2", obs_a, 5'b00001);
        cyc(); chk("same_idle", obs_a, 5'b00000);
        cyc(); chk("same_second", obs_a, 5'b10101);
        cyc(); cyc(); cyc(); chk("same_done", obs_a, 5'b00000);
`else
        chk("mir_q_after_set", {4'b0, if_a.q_mirror}, 5'b00001);
        if_a.set_req = 1'b1; cyc(); if_a.set_req = 1'b0;
        chk("mir_redundant_ack", obs_a, 5'b00100);
        cyc(); chk("mir_no_pulse", obs_a, 5'b00000);
        if_a.clr_req = 1'b1; cyc(); if_a.clr_req = 1'b0;
        chk("mir_clr_pulse", obs_a, 5'b01011);
        cyc(); chk("mir_clr_gap", obs_a, 5'b00001);
        chk("mir_q_after_clr", {4'b0, if_a.q_mirror}, 5'b00000);
        cyc(); cyc(); chk("mir_idle", obs_a, 5'b00000);
        if_a.set_req = 1'b1; if_a.clr_req = 1'b1; cyc();
        if_a.set_req = 1'b0; if_a.clr_req = 1'b0;
        chk("mir_tie_red_clr", obs_a, 5'b00010);
        cyc(); chk("mir_tie_set", obs_a, 5'b10101);
        cyc(); chk("mir_tie_q", {4'b0, if_a.q_mirror}, 5'b00001);
`endif

        // Burst merge on B: clear held 6 edges during an s pulse
        if_b.set_req = 1'b1; cyc(); if_b.set_req = 1'b0;
        for (int k = 0; k < 13; k++) begin
            chk($sformatf("burst_%0d", k), obs_b, {ev_s[k], ev_r[k], ev_sa[k], ev_ca[k], ev_b[k]});
            if_b.clr_req = (k <= 5);
            cyc();
        end

        // Reset in the 2nd drive cycle of a 4-cycle pulse on C, with a clear pending
        if_c.set_req = 1'b1; cyc(); if_c.set_req = 1'b0; if_c.clr_req = 1'b1;
        chk("rstmid_c1", obs_c, 5'b10101);
        cyc(); if_c.clr_req = 1'b0;
        chk("rstmid_c2", obs_c, 5'b10001);
        rst_n_c = 1'b0; #1;
        chk("rstmid_now", obs_c, 5'b00000);
`ifdef SR_MIRROR_EN
        chk("rstmid_qm", {4'b0, if_c.q_mirror}, 5'b00000);
`endif
        cyc(); cyc(); rst_n_c = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk($sformatf("rstmid_after_%0d", k), obs_c, 5'b00000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
